// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, field positions, default widths.
package mips_pkg;

  localparam int unsigned NB_REG_DEF  = 32;
  localparam int unsigned NB_ADDR_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SH_MSB    = 10;
  localparam int unsigned SH_LSB    = 6;
  localparam int unsigned FN_MSB    = 5;
  localparam int unsigned FN_LSB    = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned TGT_MSB   = 25;
  localparam int unsigned TGT_LSB   = 0;
  localparam int unsigned IMM_WIDTH = 16;

endpackage

// File: rtl/register_file.sv
// 2**NB_ADDR x NB_REG register file: two async read ports, one sync write port,
// async active-low clear, register 0 hardwired to zero.
// Optional macro ID_WB_BYPASS_EN: a read of the register being written this
// cycle returns the write data (write-then-read in one cycle).
// Ports:
//   i_clk, i_reset (async active-low clear)
//   i_en          : clock enable, 0 freezes contents
//   i_we, i_waddr, i_wdata : write port
//   i_raddr_a/b -> o_rdata_a/b : async read ports
import mips_pkg::*;

module register_file #(
  parameter int unsigned NB_REG  = NB_REG_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_REG-1:0]  i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr_a,
  input  logic [NB_ADDR-1:0] i_raddr_b,
  output logic [NB_REG-1:0]  o_rdata_a,
  output logic [NB_REG-1:0]  o_rdata_b
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR;

  logic [NB_REG-1:0] mem [DEPTH];
  logic              wr_fire;

  assign wr_fire = i_we && i_en && (i_waddr != '0);

  // Storage with async clear
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports; address 0 always reads zero
  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : mem[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : mem[i_raddr_b];
`ifdef ID_WB_BYPASS_EN
    if (wr_fire && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
    if (wr_fire && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, field decode, sign extension,
// branch/jump target computation and in-ID branch resolution.
// Optional macro ID_WB_BYPASS_EN enables same-cycle WB->read bypass.
// Ports:
//   i_clk, i_reset (async active-low), i_dunit_clk_en (freezes regfile)
//   WB write: i_regWrite_from_WB, i_WB_addr, i_WB_data
//   decode in: i_inst_from_IF, i_pcplus4
//   branch in: i_aluResult, i_forwardA/B, i_branch, i_isBeq
//   outputs (combinational): jump/branch targets, PCSrc, pc+8, sign-extended
//   imm, rs/rt data, rs/rt/rd addresses, shamt
import mips_pkg::*;

module id_stage #(
  parameter int unsigned NB_REG  = NB_REG_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic               i_regWrite_from_WB,
  input  logic               i_forwardA,
  input  logic               i_forwardB,
  input  logic [NB_REG-1:0]  i_inst_from_IF,
  input  logic [NB_REG-1:0]  i_pcplus4,
  input  logic [NB_ADDR-1:0] i_WB_addr,
  input  logic [NB_REG-1:0]  i_WB_data,
  input  logic [NB_REG-1:0]  i_aluResult,
  input  logic               i_isBeq,
  input  logic               i_branch,
  output logic [NB_REG-1:0]  o_pc_jsel_to_IF,
  output logic               o_PCSrc_to_IF,
  output logic [NB_REG-1:0]  o_branch_target,
  output logic [NB_REG-1:0]  o_pcplus8,
  output logic [NB_REG-1:0]  o_inst_sign_extended,
  output logic [NB_REG-1:0]  o_rs_data,
  output logic [NB_ADDR-1:0] o_op_r_tipe,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic [NB_REG-1:0]  o_rt_data
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [NB_REG-1:0] cmp_a;
  logic [NB_REG-1:0] cmp_b;
  logic              equal;
  logic              is_jr;

  assign opcode      = i_inst_from_IF[OPC_MSB:OPC_LSB];
  assign funct       = i_inst_from_IF[FN_MSB:FN_LSB];
  assign o_rs_addr   = i_inst_from_IF[RS_MSB:RS_LSB];
  assign o_rt_addr   = i_inst_from_IF[RT_MSB:RT_LSB];
  assign o_rd_addr   = i_inst_from_IF[RD_MSB:RD_LSB];
  assign o_op_r_tipe = i_inst_from_IF[SH_MSB:SH_LSB];

  register_file #(
    .NB_REG  (NB_REG),
    .NB_ADDR (NB_ADDR)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_dunit_clk_en),
    .i_we      (i_regWrite_from_WB),
    .i_waddr   (i_WB_addr),
    .i_wdata   (i_WB_data),
    .i_raddr_a (o_rs_addr),
    .i_raddr_b (o_rt_addr),
    .o_rdata_a (o_rs_data),
    .o_rdata_b (o_rt_data)
  );

  // Immediate and sequential-PC arithmetic (all wrap modulo 2**NB_REG)
  assign o_inst_sign_extended = {{(NB_REG-IMM_WIDTH){i_inst_from_IF[IMM_MSB]}},
                                 i_inst_from_IF[IMM_MSB:IMM_LSB]};
  assign o_branch_target = i_pcplus4 + {o_inst_sign_extended[NB_REG-3:0], 2'b00};
  assign o_pcplus8       = i_pcplus4 + NB_REG'(4);

  // Branch compare uses forwarded operands; data outputs stay unforwarded
  assign cmp_a         = i_forwardA ? i_aluResult : o_rs_data;
  assign cmp_b         = i_forwardB ? i_aluResult : o_rt_data;
  assign equal         = (cmp_a == cmp_b);
  assign o_PCSrc_to_IF = i_branch && (i_isBeq ? equal : !equal);

  // Register jumps take forwarded rs; everything else gets the J-format target
  assign is_jr = (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
  assign o_pc_jsel_to_IF = is_jr ? cmp_a
                                 : {i_pcplus4[NB_REG-1:NB_REG-4],
                                    i_inst_from_IF[TGT_MSB:TGT_LSB], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_dunit_clk_en, i_regWrite_from_WB;
  logic        i_forwardA, i_forwardB, i_isBeq, i_branch;
  logic [31:0] i_inst_from_IF, i_pcplus4, i_WB_data, i_aluResult;
  logic [4:0]  i_WB_addr;
  logic [31:0] o_pc_jsel_to_IF, o_branch_target, o_pcplus8, o_inst_sign_extended;
  logic [31:0] o_rs_data, o_rt_data;
  logic        o_PCSrc_to_IF;
  logic [4:0]  o_op_r_tipe, o_rs_addr, o_rt_addr, o_rd_addr;

  always #5 clk = ~clk;

  id_stage dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_dunit_clk_en       (i_dunit_clk_en),
    .i_regWrite_from_WB   (i_regWrite_from_WB),
    .i_forwardA           (i_forwardA),
    .i_forwardB           (i_forwardB),
    .i_inst_from_IF       (i_inst_from_IF),
    .i_pcplus4            (i_pcplus4),
    .i_WB_addr            (i_WB_addr),
    .i_WB_data            (i_WB_data),
    .i_aluResult          (i_aluResult),
    .i_isBeq              (i_isBeq),
    .i_branch             (i_branch),
    .o_pc_jsel_to_IF      (o_pc_jsel_to_IF),
    .o_PCSrc_to_IF        (o_PCSrc_to_IF),
    .o_branch_target      (o_branch_target),
    .o_pcplus8            (o_pcplus8),
    .o_inst_sign_extended (o_inst_sign_extended),
    .o_rs_data            (o_rs_data),
    .o_op_r_tipe          (o_op_r_tipe),
    .o_rs_addr            (o_rs_addr),
    .o_rt_addr            (o_rt_addr),
    .o_rd_addr            (o_rd_addr),
    .o_rt_data            (o_rt_data)
  );

  typedef struct {
    string       name;
    logic [31:0] jsel, btgt, pc8, sext, rs_d, rt_d;
    logic        pcsrc;
    logic [4:0]  sh, rs_a, rt_a, rd_a;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] regs_m [32];
  logic        pend_we;
  logic [4:0]  pend_wa;
  logic [31:0] pend_wd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%08h expected=%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "rs_data", o_rs_data, e.rs_d);
      chk(e.name, "rt_data", o_rt_data, e.rt_d);
      chk(e.name, "sext",    o_inst_sign_extended, e.sext);
      chk(e.name, "btgt",    o_branch_target, e.btgt);
      chk(e.name, "pc8",     o_pcplus8, e.pc8);
      chk(e.name, "pcsrc",   32'(o_PCSrc_to_IF), 32'(e.pcsrc));
      chk(e.name, "jsel",    o_pc_jsel_to_IF, e.jsel);
      chk(e.name, "addr",    {12'h0, o_rs_addr, o_rt_addr, o_rd_addr, o_op_r_tipe},
                             {12'h0, e.rs_a, e.rt_a, e.rd_a, e.sh});
    end
  end

  function automatic logic [31:0] read_m(input logic [4:0] a, input logic rst,
                                         input logic we_eff, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (!rst) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we_eff && wa == a) return wd;
`endif
    return regs_m[a];
  endfunction

  // One cycle of stimulus: commit last cycle's write, drive, predict, enqueue
  task automatic drive(input string nm, input logic rst, input logic we, input logic en,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] inst, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic fa, input logic fb,
                       input logic br, input logic beq);
    exp_t        e;
    logic        we_eff;
    logic [31:0] a, b, imm;
    logic        eq;
    @(posedge clk);
    if (pend_we) regs_m[pend_wa] = pend_wd;
    #1;
    i_reset = rst; i_regWrite_from_WB = we; i_dunit_clk_en = en;
    i_WB_addr = wa; i_WB_data = wd; i_inst_from_IF = inst; i_pcplus4 = pc4;
    i_aluResult = alu; i_forwardA = fa; i_forwardB = fb; i_branch = br; i_isBeq = beq;
    if (!rst) for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
    we_eff  = rst && we && en && (wa != 5'd0);
    pend_we = we_eff; pend_wa = wa; pend_wd = wd;

    e.name = nm;
    e.rs_a = inst[25:21]; e.rt_a = inst[20:16]; e.rd_a = inst[15:11]; e.sh = inst[10:6];
    e.rs_d = read_m(inst[25:21], rst, we_eff, wa, wd);
    e.rt_d = read_m(inst[20:16], rst, we_eff, wa, wd);
    imm    = 32'(signed'(inst[15:0]));
    e.sext = imm;
    e.btgt = pc4 + imm * 4;
    e.pc8  = pc4 + 32'd4;
    a      = fa ? alu : e.rs_d;
    b      = fb ? alu : e.rt_d;
    eq     = (a == b);
    e.pcsrc = br && (beq ? eq : !eq);
    if (inst[31:26] == 6'd0 && (inst[5:0] == 6'd8 || inst[5:0] == 6'd9))
      e.jsel = a;
    else
      e.jsel = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
    sb_q.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [31:0] inst, input logic [31:0] pc4);
    drive(nm, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0, inst, pc4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic br(input string nm, input logic [31:0] inst, input logic [31:0] alu,
                    input logic fa, input logic beq);
    drive(nm, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0, inst, 32'h100, alu, fa, 1'b0, 1'b1, beq);
  endtask

  initial begin
    pend_we = 1'b0; pend_wa = '0; pend_wd = '0;
    for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
    i_reset = 1'b0; i_dunit_clk_en = 1'b1; i_regWrite_from_WB = 1'b0;
    i_forwardA = 1'b0; i_forwardB = 1'b0; i_isBeq = 1'b0; i_branch = 1'b0;
    i_inst_from_IF = '0; i_pcplus4 = '0; i_WB_data = '0; i_aluResult = '0; i_WB_addr = '0;

    // Reset, then read after release
    drive("reset", 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, {6'h0, 5'd1, 5'd2, 16'h0}, 32'h0,
          32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd("post_reset", {6'h0, 5'd1, 5'd2, 16'h0}, 32'h0);

    // Fill the register file
    for (int k = 0; k < 32; k++)
      drive("fill", 1'b1, 1'b1, 1'b1, 5'(k), 32'hDEADBEEF + 32'(k), 32'h0, 32'h0,
            32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd("read12", {6'h0, 5'd1, 5'd2, 16'h0001}, 32'h0);
    rd("read_r0", {6'h0, 5'd0, 5'd31, 16'h0}, 32'h0);

    // Branch target / pc+8
    rd("btgt_pos", {6'h04, 5'd0, 5'd0, 16'h0004}, 32'h8);
    rd("btgt_neg", {6'h04, 5'd0, 5'd0, 16'hFFFF}, 32'h8);
    rd("btgt_wrap", {6'h04, 5'd0, 5'd0, 16'h7FFF}, 32'hFFFF_FFF8);

    // Branch resolution
    br("beq_eq", {6'h04, 5'd0, 5'd0, 16'h0}, 32'h0, 1'b0, 1'b1);
    br("bne_eq", {6'h05, 5'd0, 5'd0, 16'h0}, 32'h0, 1'b0, 1'b0);
    br("beq_fwd", {6'h04, 5'd0, 5'd0, 16'h0}, 32'h5, 1'b1, 1'b1);
    br("bne_fwd", {6'h05, 5'd0, 5'd0, 16'h0}, 32'h5, 1'b1, 1'b0);
    drive("nobranch", 1'b1, 1'b0, 1'b1, 5'd0, 32'h0, {6'h04, 5'd0, 5'd0, 16'h0}, 32'h0,
          32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Jumps
    rd("j_tgt", {6'h02, 26'h0000100}, 32'h1000_0004);
    rd("jr_rs1", {6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 6'h08}, 32'h1000_0004);
    drive("jalr_fwd", 1'b1, 1'b0, 1'b1, 5'd0, 32'h0, {6'h00, 5'd1, 5'd0, 5'd31, 5'd0, 6'h09},
          32'h40, 32'hCAFE_0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Freeze, then same-cycle read of a written register
    drive("frozen_wr", 1'b1, 1'b1, 1'b0, 5'd3, 32'h1234_5678, {6'h0, 5'd3, 5'd3, 16'h0},
          32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd("frozen_rd", {6'h0, 5'd3, 5'd4, 16'h0}, 32'h0);
    drive("wr_same", 1'b1, 1'b1, 1'b1, 5'd4, 32'hA5A5_0004, {6'h0, 5'd3, 5'd4, 16'h0},
          32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd("wr_after", {6'h0, 5'd4, 5'd3, 16'h0}, 32'h0);
    drive("wr_r0", 1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, {6'h0, 5'd0, 5'd0, 16'h0},
          32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd("r0_after", {6'h0, 5'd0, 5'd4, 16'h0}, 32'h0);

    // Randomized traffic, with rare mid-operation resets
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 3) == 0) inst = {6'h0, inst[25:6], 6'(8 + $urandom_range(0, 1))};
      drive("rand", ($urandom_range(0, 63) != 0), 1'($urandom), ($urandom_range(0, 7) != 0),
            5'($urandom), $urandom, inst, $urandom, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom));
    end
    rd("after_rand", {6'h0, 5'd7, 5'd9, 16'h0}, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
